// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO with registered read data and sends each word as a UART frame.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  pop,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [IDX_W-1:0]      bit_idx;
   logic [CNT_W-1:0]      baud_cnt;
   logic                  baud_end;
   logic [IDX_W-1:0]      next_idx;

   assign baud_end = (baud_cnt == CNT_LAST);
   assign next_idx = bit_idx + IDX_W'(1);
   assign busy     = (state != IDLE);

   // tx is loaded on the edge that enters each bit so the line changes exactly on bit boundaries.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= IDLE;
         tx         <= 1'b1;
         pop        <= 1'b0;
         frame_done <= 1'b0;
         shift_reg  <= '0;
         bit_idx    <= '0;
         baud_cnt   <= '0;
      end else begin
         pop        <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && !empty) begin
                  state <= POP;
                  pop   <= 1'b1;
               end
            end
            POP: begin
               state <= LOAD;
            end
            // The FIFO presents the popped word one cycle after the strobe, so capture it here.
            LOAD: begin
               shift_reg <= fifo_data;
               baud_cnt  <= '0;
               tx        <= 1'b0;
               state     <= START;
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     tx    <= ^shift_reg;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= next_idx;
                     tx      <= shift_reg[next_idx];
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (baud_end) begin
                  baud_cnt   <= '0;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a small registered-read FIFO model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fifo_uart_tx;

   localparam int DW    = 8;
   localparam int CPB   = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;
   localparam int LOG_N     = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          empty;
   logic [DW-1:0] fifo_data = '0;
   logic          pop;
   logic          tx;
   logic          busy;
   logic          frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] mem [16];
   logic [3:0]    wr_ptr = 4'd0;
   logic [3:0]    rd_ptr = 4'd0;

   logic pop_log  [LOG_N];
   logic tx_log   [LOG_N];
   logic busy_log [LOG_N];
   logic fd_log   [LOG_N];
   int   n_logged = 0;
   int   pop_idx  [4];
   int   n_pops;
   int   fd_idx;
   int   n_fd;

   fifo_uart_tx #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .empty     (empty),
      .fifo_data (fifo_data),
      .pop       (pop),
      .tx        (tx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // FIFO model: data_out becomes valid one cycle after the pop strobe.
   assign empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (pop === 1'b1 && rd_ptr != wr_ptr) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 4'd1;
      end
   end

   task automatic push_word(input logic [DW-1:0] w);
      mem[wr_ptr] = w;
      wr_ptr      = wr_ptr + 4'd1;
   endtask

   task automatic capture(input int n, input int drop_after_pop);
      int first_pop;
      first_pop = -1;
      n_pops    = 0;
      n_fd      = 0;
      fd_idx    = -1;
      pop_idx   = '{default: -1};
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pop_log[i]  = pop;
         tx_log[i]   = tx;
         busy_log[i] = busy;
         fd_log[i]   = frame_done;
         if (pop === 1'b1) begin
            if (n_pops < 4) pop_idx[n_pops] = i;
            n_pops++;
            if (first_pop < 0) first_pop = i;
         end
         if (frame_done === 1'b1) begin
            if (fd_idx < 0) fd_idx = i;
            n_fd++;
         end
         if (drop_after_pop >= 0 && first_pop >= 0 && i == first_pop + drop_after_pop) enable = 1'b0;
      end
      n_logged = n;
   endtask

   // Value of frame bit k starting at log index st, or x if the bit was not held steady.
   function automatic logic frame_bit(input int st, input int k);
      int   idx;
      logic b;
      idx = st + k * CPB;
      if (st < 0 || idx + CPB > n_logged) return 1'bx;
      b = tx_log[idx];
      for (int j = 1; j < CPB; j++) begin
         if (tx_log[idx + j] !== b) return 1'bx;
      end
      return b;
   endfunction

   function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
      if (k == 0) return 1'b0;
      if (k <= DW) return w[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
      if (k == DW + 1) return ^w;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset;
      rst_n  = 1'b1;
      enable = 1'b1;
      push_word(8'h55);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({tx, pop, busy, frame_done} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_hold cycle %0d: tx/pop/busy/done=%b expected 1000", c, {tx, pop, busy, frame_done});
         end
      end
      rst_n = 1'b0;
      n_checks++;
      if (pop !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_release_pop: got %b expected 0", pop);
      end
      @(negedge clk);
      n_checks++;
      if (pop !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL first_pop: pop/busy=%b%b expected 11", pop, busy);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b0 || pop !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL start_bit_latency: tx/pop=%b%b expected 00", tx, pop);
      end
      #2 rst_n = 1'b1;
      #1;
      n_checks++;
      if ({tx, pop, busy, frame_done} !== 4'b1000) begin
         n_fail++;
         $display("[TB] FAIL async_reset_midframe: tx/pop/busy/done=%b expected 1000", {tx, pop, busy, frame_done});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
   endtask

   task automatic test_idle_empty;
      int pop_seen, tx_low, busy_seen;
      pop_seen  = 0;
      tx_low    = 0;
      busy_seen = 0;
      enable    = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (pop !== 1'b0) pop_seen++;
         if (tx !== 1'b1) tx_low++;
         if (busy !== 1'b0) busy_seen++;
      end
      n_checks++;
      if (pop_seen !== 0) begin
         n_fail++;
         $display("[TB] FAIL empty_no_pop: %0d pop cycles, expected 0", pop_seen);
      end
      n_checks++;
      if (tx_low !== 0) begin
         n_fail++;
         $display("[TB] FAIL empty_tx_idle: %0d non-high cycles, expected 0", tx_low);
      end
      n_checks++;
      if (busy_seen !== 0) begin
         n_fail++;
         $display("[TB] FAIL empty_not_busy: %0d busy cycles, expected 0", busy_seen);
      end
   endtask

   task automatic test_single_frame;
      int   p, busy_cnt;
      logic obs;
      push_word(8'hA5);
      capture(80, -1);
      p = pop_idx[0];
      n_checks++;
      if (n_pops !== 1) begin
         n_fail++;
         $display("[TB] FAIL single_pop_count: got %0d expected 1", n_pops);
      end
      busy_cnt = 0;
      for (int i = 0; i < 80; i++) if (busy_log[i] === 1'b1) busy_cnt++;
      n_checks++;
      if (busy_cnt !== FRAME_CYC + 2) begin
         n_fail++;
         $display("[TB] FAIL single_busy_cycles: got %0d expected %0d", busy_cnt, FRAME_CYC + 2);
      end
      for (int k = 0; k < NBITS; k++) begin
         obs = frame_bit(p + 2, k);
         n_checks++;
         if (obs !== exp_bit(8'hA5, k)) begin
            n_fail++;
            $display("[TB] FAIL a5_bit%0d: got %b expected %b", k, obs, exp_bit(8'hA5, k));
         end
      end
      n_checks++;
      if (n_fd !== 1 || fd_idx !== p + 2 + FRAME_CYC) begin
         n_fail++;
         $display("[TB] FAIL single_frame_done: %0d pulses at %0d, expected 1 at %0d", n_fd, fd_idx, p + 2 + FRAME_CYC);
      end
   endtask

   task automatic test_back_to_back;
      int   p1, p2, run, i;
      logic obs;
      push_word(8'h00);
      push_word(8'hFF);
      capture(110, -1);
      p1 = pop_idx[0];
      p2 = pop_idx[1];
      n_checks++;
      if (n_pops !== 2) begin
         n_fail++;
         $display("[TB] FAIL b2b_pop_count: got %0d expected 2", n_pops);
      end
      n_checks++;
      if (p2 - p1 !== FRAME_CYC + 3) begin
         n_fail++;
         $display("[TB] FAIL b2b_pop_spacing: got %0d expected %0d", p2 - p1, FRAME_CYC + 3);
      end
      run = 0;
      i   = (p2 >= 0) ? p2 + 1 : 0;
      while (i >= 0 && i < n_logged && tx_log[i] === 1'b1) begin
         run++;
         i--;
      end
      n_checks++;
      if (run !== CPB + 3) begin
         n_fail++;
         $display("[TB] FAIL b2b_line_high: got %0d cycles expected %0d", run, CPB + 3);
      end
      for (int k = 0; k < NBITS; k++) begin
         obs = frame_bit(p1 + 2, k);
         n_checks++;
         if (obs !== exp_bit(8'h00, k)) begin
            n_fail++;
            $display("[TB] FAIL b2b_00_bit%0d: got %b expected %b", k, obs, exp_bit(8'h00, k));
         end
      end
      for (int k = 0; k < NBITS; k++) begin
         obs = frame_bit(p2 + 2, k);
         n_checks++;
         if (obs !== exp_bit(8'hFF, k)) begin
            n_fail++;
            $display("[TB] FAIL b2b_ff_bit%0d: got %b expected %b", k, obs, exp_bit(8'hFF, k));
         end
      end
      n_checks++;
      if (n_fd !== 2) begin
         n_fail++;
         $display("[TB] FAIL b2b_frame_done: got %0d pulses expected 2", n_fd);
      end
   endtask

   task automatic test_enable_drop;
      int   p, seen;
      logic obs;
      enable = 1'b1;
      push_word(8'h3C);
      push_word(8'h99);
      capture(110, 19);
      p = pop_idx[0];
      n_checks++;
      if (n_pops !== 1) begin
         n_fail++;
         $display("[TB] FAIL drop_pop_count: got %0d expected 1", n_pops);
      end
      for (int k = 0; k < NBITS; k++) begin
         obs = frame_bit(p + 2, k);
         n_checks++;
         if (obs !== exp_bit(8'h3C, k)) begin
            n_fail++;
            $display("[TB] FAIL drop_3c_bit%0d: got %b expected %b", k, obs, exp_bit(8'h3C, k));
         end
      end
      n_checks++;
      if (n_fd !== 1 || busy_log[n_logged-1] !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL drop_frame_end: %0d pulses busy=%b, expected 1 pulse busy=0", n_fd, busy_log[n_logged-1]);
      end
      enable = 1'b1;
      seen   = 0;
      for (int c = 0; c < 6 && seen == 0; c++) begin
         @(negedge clk);
         if (pop === 1'b1) seen = 1;
      end
      n_checks++;
      if (seen !== 1) begin
         n_fail++;
         $display("[TB] FAIL reenable_pop: got no pop, expected pop within 6 cycles");
      end
      seen = 0;
      for (int c = 0; c < 3 * FRAME_CYC && seen == 0; c++) begin
         @(negedge clk);
         if (frame_done === 1'b1) seen = 1;
      end
      n_checks++;
      if (seen !== 1) begin
         n_fail++;
         $display("[TB] FAIL reenable_frame_done: got none, expected a pulse within %0d cycles", 3 * FRAME_CYC);
      end
   endtask

`ifdef FIFO_UART_TX_PARITY_EN
   task automatic test_parity;
      int   p;
      logic obs;
      push_word(8'h07);
      capture(60, -1);
      p   = pop_idx[0];
      obs = frame_bit(p + 2, 9);
      n_checks++;
      if (obs !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL parity_07: got %b expected 1", obs);
      end
      n_checks++;
      if (fd_idx !== p + 2 + 44) begin
         n_fail++;
         $display("[TB] FAIL parity_frame_len: done at %0d expected %0d", fd_idx, p + 2 + 44);
      end
      push_word(8'h03);
      capture(60, -1);
      p   = pop_idx[0];
      obs = frame_bit(p + 2, 9);
      n_checks++;
      if (obs !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL parity_03: got %b expected 0", obs);
      end
      obs = frame_bit(p + 2, 10);
      n_checks++;
      if (obs !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL parity_03_stop: got %b expected 1", obs);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_idle_empty();
      test_single_frame();
      test_back_to_back();
      test_enable_drop();
`ifdef FIFO_UART_TX_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the FIFO memory: drains queued words and transmits each one as an asynchronous serial frame on a single tx line.
- Start bit, then DATA_WIDTH data bits LSB first, an optional parity bit, then one stop bit.
- Connects directly to the FIFO's pop, empty and data_out signals, and accounts for the FIFO's one-cycle registered read latency.

Parameters:
- DATA_WIDTH, 8, word width. Must match the FIFO's DATA_WIDTH.
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be at least 2. The baud counter is $clog2(CLKS_PER_BIT) bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-high despite the name; same convention as the FIFO.
- enable  input  1  permits starting new frames.
- empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO data_out.
- pop  output  1  FIFO read strobe, registered.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high whenever state is not IDLE.
- frame_done  output  1  one-cycle pulse after each stop bit completes.

Behaviour:
- Reset: asynchronous and active-high, effective immediately. Outputs: state=IDLE, tx=1, pop=0, busy=0, frame_done=0. Shift register, bit index and baud counter are cleared to 0.
- States: IDLE, POP, LOAD, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: if enable=1 and empty=0 at a rising edge, go to POP; otherwise stay.
- POP: pop=1 for exactly this one cycle. Next state is LOAD unconditionally. pop is never high for two consecutive cycles.
- LOAD: the FIFO's data_out is now valid. At the end of this cycle, capture fifo_data into the shift register, clear the baud counter and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[bit index] for CLKS_PER_BIT cycles per bit. After bit DATA_WIDTH-1, go to PARITY if the feature is enabled, otherwise to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the exit edge, pulse frame_done=1 for one cycle and go to IDLE.
- Latency: the first START cycle begins 2 cycles after pop rises.
- Frame length: (DATA_WIDTH+2) x CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
- Back-to-back frames: the line stays high for CLKS_PER_BIT+3 cycles between frames (stop bit, then IDLE, POP and LOAD).
- empty is sampled only in IDLE. It is not rechecked in POP or LOAD.
- enable falling mid-frame: the current frame completes normally. No new pop is issued until enable=1 again.
- empty rising mid-frame has no effect on the frame in progress.
- Reset mid-frame: tx returns to 1 at once and the frame is abandoned. The word already popped is lost; this is acceptable.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. The bit index advances only on the wrap.
- fifo_data is ignored in every state except LOAD.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives tx = XOR of all captured data bits (even parity) for CLKS_PER_BIT cycles.
- When undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

Test Plan:
- Assert rst_n=1 for 3 cycles with enable=1, empty=0 -> tx=1, pop=0, busy=0, frame_done=0 throughout; no pop until 1 cycle after release.
- CLKS_PER_BIT=4; FIFO model holding 0xA5; enable=1 -> a single 1-cycle pop; tx for 4 cycles each: 0,1,0,1,0,0,1,0,1,1; one frame_done pulse; busy high for 42 cycles (IDLE exit to STOP end).
- empty=1, enable=1 for 50 cycles -> pop stays 0, tx stays 1, busy stays 0.
- FIFO holding 0x00 then 0xFF -> exactly two pops; line high between frames for 7 cycles (CLKS_PER_BIT+3); second frame's data bits all 1.
- enable driven 0 during data bit 3 of 0x3C, FIFO still non-empty -> frame completes with the correct bits; no further pop until enable=1.
- With FIFO_UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1; frame is 11 bits; send 0x03 -> parity bit 0.
